alu_share_arbiter: RTL and testbench

Sequences and arbitrates one shared combinational ALU between two requesters, e.g. the execute stage (port 0) and a branch/compare or debug unit (port 1). Each requester presents a 4-bit ALU control code and two operands under a valid/ready handshake. The block grants round-robin, registers the operands and drives the ALU for one cycle. It then holds the result in a response register until the owning requester accepts it. It sits between the ALU control decoder outputs and the ALU.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/rr_arb2.sv | 35 +++
 rtl/alu_share_arbiter.sv | 154 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes, legality check and sequencer state encoding
package alu_pkg;

   // ALU control codes shared with the ALU_Control decoder
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLTU = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b1001;
   localparam logic [3:0] ALU_SRL  = 4'b1010;
   localparam logic [3:0] ALU_SRA  = 4'b1011;

   // Sequencer states: one operation in flight at a time
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // Unsupported codes still reach the ALU; this only flags them in the response
   function automatic logic is_legal_ctrl(input logic [3:0] ctrl);
      logic legal;
      case (ctrl)
         ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SUB,
         ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA: legal = 1'b1;
         default:                                      legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-request round-robin arbiter with grant enable and registered last-grant pointer
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt
);

   // Port granted most recently; reset to 1 so port 0 wins the first tie
   logic last;

   // Single requester wins outright; a tie goes to the port not granted last
   always_comb begin
      gnt = 2'b00;
      if (en) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

   // Pointer moves only when a grant is actually issued
   always_ff @(posedge clk) begin
      if (reset) begin
         last <= 1'b1;
      end else if (|gnt) begin
         last <= gnt[1];
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sequencer sharing one combinational ALU between two requesters
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,

   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_ctrl,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,

   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_ctrl,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,

   output logic             resp0_valid,
   input  logic             resp0_ready,
   output logic [WIDTH-1:0] resp0_result,
   output logic             resp0_zero,
   output logic             resp0_illegal,

   output logic             resp1_valid,
   input  logic             resp1_ready,
   output logic [WIDTH-1:0] resp1_result,
   output logic             resp1_zero,
   output logic             resp1_illegal,

   output logic [3:0]       alu_ctrl,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero
);

   logic [1:0]             state;
   logic [1:0]             gnt;
   logic                   grant_en;

   // Operand registers for the single in-flight operation
   logic [3:0]             op_ctrl;
   logic [WIDTH-1:0]       op_a;
   logic [WIDTH-1:0]       op_b;
   logic                   op_port;
   logic                   op_illegal;

   // Per-port response registers
   logic [1:0]             rsp_valid;
   logic [1:0][WIDTH-1:0]  rsp_result;
   logic [1:0]             rsp_zero;
   logic [1:0]             rsp_illegal;

   logic                   owner_ready;

   // Requests are only considered while idle, so ready never depends on payload
   assign grant_en = (state == ST_IDLE);

   rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   ({req1_valid, req0_valid}),
      .en    (grant_en),
      .gnt   (gnt)
   );

   assign req0_ready = gnt[0];
   assign req1_ready = gnt[1];

   // The owning port's accept; the other port's resp ready is ignored
   assign owner_ready = op_port ? resp1_ready : resp0_ready;

   // Sequencer: accept in IDLE, one ALU cycle in EXEC, hold result in RESP
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (|gnt)       state <= ST_EXEC;
            ST_EXEC:                 state <= ST_RESP;
            ST_RESP: if (owner_ready) state <= ST_IDLE;
            default:                 state <= ST_IDLE;
         endcase
      end
   end

   // Capture the winner's payload at the grant edge
   always_ff @(posedge clk) begin
      if (reset) begin
         op_ctrl    <= 4'b0000;
         op_a       <= '0;
         op_b       <= '0;
         op_port    <= 1'b0;
         op_illegal <= 1'b0;
      end else if (|gnt) begin
         op_port    <= gnt[1];
         op_ctrl    <= gnt[1] ? req1_ctrl : req0_ctrl;
         op_a       <= gnt[1] ? req1_a    : req0_a;
         op_b       <= gnt[1] ? req1_b    : req0_b;
         op_illegal <= !is_legal_ctrl(gnt[1] ? req1_ctrl : req0_ctrl);
      end
   end

   // ALU sees the operands only during EXEC; otherwise it is parked at zero
   always_comb begin
      alu_ctrl = 4'b0000;
      alu_a    = '0;
      alu_b    = '0;
      if (state == ST_EXEC) begin
         alu_ctrl = op_ctrl;
         alu_a    = op_a;
         alu_b    = op_b;
      end
   end

   // Response data for the owning port is written once, at the end of EXEC, and then held
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_result  <= '0;
         rsp_zero    <= 2'b00;
         rsp_illegal <= 2'b00;
      end else if (state == ST_EXEC) begin
         rsp_result[op_port]  <= alu_result;
         rsp_zero[op_port]    <= alu_zero;
         rsp_illegal[op_port] <= op_illegal;
      end
   end

   // Response valid rises after EXEC and falls on the owner's accept
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid <= 2'b00;
      end else if (state == ST_EXEC) begin
         rsp_valid[op_port] <= 1'b1;
      end else if ((state == ST_RESP) && owner_ready) begin
         rsp_valid[op_port] <= 1'b0;
      end
   end

   assign resp0_valid   = rsp_valid[0];
   assign resp0_result  = rsp_result[0];
   assign resp0_zero    = rsp_zero[0];
   assign resp0_illegal = rsp_illegal[0];

   assign resp1_valid   = rsp_valid[1];
   assign resp1_result  = rsp_result[1];
   assign resp1_zero    = rsp_zero[1];
   assign resp1_illegal = rsp_illegal[1];

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter with behavioural model
module tb_alu_share_arbiter;

   logic             clk = 1'b0;
   logic             reset;
   logic [1:0]       rq_valid, rq_ready;
   logic [1:0][3:0]  rq_ctrl;
   logic [1:0][31:0] rq_a, rq_b;
   logic [1:0]       rs_valid, rs_ready, rs_zero, rs_ill;
   logic [1:0][31:0] rs_res;
   logic [3:0]       alu_ctrl;
   logic [31:0]      alu_a, alu_b, alu_result;
   logic             alu_zero;

   int checks = 0;
   int passes = 0;
   bit model_on = 1'b0;

   always #5 clk = ~clk;

   alu_share_arbiter #(.WIDTH(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .req0_valid   (rq_valid[0]),
      .req0_ready   (rq_ready[0]),
      .req0_ctrl    (rq_ctrl[0]),
      .req0_a       (rq_a[0]),
      .req0_b       (rq_b[0]),
      .req1_valid   (rq_valid[1]),
      .req1_ready   (rq_ready[1]),
      .req1_ctrl    (rq_ctrl[1]),
      .req1_a       (rq_a[1]),
      .req1_b       (rq_b[1]),
      .resp0_valid  (rs_valid[0]),
      .resp0_ready  (rs_ready[0]),
      .resp0_result (rs_res[0]),
      .resp0_zero   (rs_zero[0]),
      .resp0_illegal(rs_ill[0]),
      .resp1_valid  (rs_valid[1]),
      .resp1_ready  (rs_ready[1]),
      .resp1_result (rs_res[1]),
      .resp1_zero   (rs_zero[1]),
      .resp1_illegal(rs_ill[1]),
      .alu_ctrl     (alu_ctrl),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_result   (alu_result),
      .alu_zero     (alu_zero)
   );

   // Reference ALU arithmetic; unsupported codes produce a recognisable marker
   function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      case (c)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0100: return a ^ b;
         4'b0110: return a - b;
         4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b1000: return (a < b) ? 32'd1 : 32'd0;
         4'b1001: return a << b[4:0];
         4'b1010: return a >> b[4:0];
         4'b1011: return $unsigned($signed(a) >>> b[4:0]);
         default: return 32'hDEADBEEF;
      endcase
   endfunction

   function automatic bit legal_ref(input logic [3:0] c);
      return c inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11};
   endfunction

   // The shared ALU the DUT drives
   always_comb begin
      alu_result = alu_ref(alu_ctrl, alu_a, alu_b);
      alu_zero   = (alu_result == 32'd0);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h required %h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Behavioural model: transaction in flight with an age, per-port pending results
   bit          m_busy;
   int          m_age;
   int          m_port;
   int          m_prio;
   logic [3:0]  m_ctrl;
   logic [31:0] m_a, m_b;
   bit          m_rv[2];
   logic [31:0] m_rres[2];
   bit          m_rz[2], m_ri[2];

   function automatic int winner(input logic [1:0] v, input int prio);
      if (v == 2'b11) return prio;
      if (v[0]) return 0;
      if (v[1]) return 1;
      return -1;
   endfunction

   initial begin
      int w;
      logic [31:0] r;
      logic [1:0]  exp_ready;
      forever begin
         @(negedge clk);
         w = winner(rq_valid, m_prio);
         exp_ready = 2'b00;
         if (!m_busy && w >= 0) exp_ready[w] = 1'b1;
         if (model_on) begin
            chk("req_ready", {30'd0, rq_ready}, {30'd0, exp_ready});
            chk("alu_ctrl", {28'd0, alu_ctrl}, (m_busy && m_age == 1) ? {28'd0, m_ctrl} : 32'd0);
            chk("alu_a", alu_a, (m_busy && m_age == 1) ? m_a : 32'd0);
            chk("alu_b", alu_b, (m_busy && m_age == 1) ? m_b : 32'd0);
            for (int p = 0; p < 2; p++) begin
               chk($sformatf("resp%0d_valid", p), {31'd0, rs_valid[p]}, {31'd0, m_rv[p]});
               chk($sformatf("resp%0d_result", p), rs_res[p], m_rres[p]);
               chk($sformatf("resp%0d_zero", p), {31'd0, rs_zero[p]}, {31'd0, m_rz[p]});
               chk($sformatf("resp%0d_illegal", p), {31'd0, rs_ill[p]}, {31'd0, m_ri[p]});
            end
         end
         // Advance the model to the state after the coming edge
         if (reset) begin
            m_busy = 0; m_age = 0; m_port = 0; m_prio = 0;
            for (int p = 0; p < 2; p++) begin
               m_rv[p] = 0; m_rres[p] = 0; m_rz[p] = 0; m_ri[p] = 0;
            end
         end else if (!m_busy) begin
            if (w >= 0) begin
               m_busy = 1; m_age = 1; m_port = w;
               m_ctrl = rq_ctrl[w]; m_a = rq_a[w]; m_b = rq_b[w];
               m_prio = 1 - w;
            end
         end else if (m_age == 1) begin
            m_age = 2;
            r = alu_ref(m_ctrl, m_a, m_b);
            m_rv[m_port] = 1; m_rres[m_port] = r;
            m_rz[m_port] = (r == 0); m_ri[m_port] = !legal_ref(m_ctrl);
         end else if (rs_ready[m_port]) begin
            m_rv[m_port] = 0;
            m_busy = 0;
         end
      end
   end

   // One directed operation on a single port with literal expectations
   task automatic run_op(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ez, input logic ei, input string nm,
                         output int waited);
      bit got;
      tick();
      rs_ready = 2'b11;
      rq_valid[p] = 1'b1; rq_ctrl[p] = c; rq_a[p] = a; rq_b[p] = b;
      waited = 0; got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (rq_ready[p]) got = 1;
         else begin waited++; tick(); end
      end
      chk({nm, "_grant"}, {31'd0, got}, 32'd1);
      tick();
      rq_valid[p] = 1'b0;
      @(negedge clk);
      chk({nm, "_alu_driven"}, {28'd0, alu_ctrl}, {28'd0, c});
      tick();
      @(negedge clk);
      chk({nm, "_valid"}, {31'd0, rs_valid[p]}, 32'd1);
      chk({nm, "_result"}, rs_res[p], er);
      chk({nm, "_zero"}, {31'd0, rs_zero[p]}, {31'd0, ez});
      chk({nm, "_illegal"}, {31'd0, rs_ill[p]}, {31'd0, ei});
      tick();
      @(negedge clk);
      chk({nm, "_valid_clear"}, {31'd0, rs_valid[p]}, 32'd0);
      chk({nm, "_alu_parked"}, {28'd0, alu_ctrl}, 32'd0);
   endtask

   initial begin
      int waited;
      int wport;
      bit got;
      logic [1:0] seen;

      reset = 1'b1; rq_valid = '0; rq_ctrl = '0; rq_a = '0; rq_b = '0; rs_ready = '0;
      tick();
      model_on = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("reset_resp_valid", {30'd0, rs_valid}, 32'd0);
      chk("reset_req_ready", {30'd0, rq_ready}, 32'd0);
      chk("reset_result0", rs_res[0], 32'd0);
      chk("reset_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);

      // Single request, granted in its first cycle
      run_op(0, 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, "add", waited);
      chk("add_ready_first_cycle", waited, 32'd0);

      // Ties alternate from port 0 after reset while both keep requesting
      tick(); reset = 1'b1; tick(); reset = 1'b0;
      rs_ready = 2'b11;
      rq_valid = 2'b11;
      rq_ctrl[0] = 4'b0110; rq_a[0] = 32'd9;    rq_b[0] = 32'd9;
      rq_ctrl[1] = 4'b0001; rq_a[1] = 32'hF0;   rq_b[1] = 32'h0F;
      for (int g = 0; g < 4; g++) begin
         got = 0;
         for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (|rq_ready) got = 1; else tick();
         end
         chk("tie_grant", {31'd0, got}, 32'd1);
         wport = rq_ready[1] ? 1 : 0;
         chk("tie_order", wport, g % 2);
         tick();
         @(negedge clk);
         tick();
         @(negedge clk);
         chk("tie_valid", {31'd0, rs_valid[wport]}, 32'd1);
         chk("tie_result", rs_res[wport], (wport == 1) ? 32'hFF : 32'd0);
         chk("tie_zero", {31'd0, rs_zero[wport]}, (wport == 1) ? 32'd0 : 32'd1);
         tick();
      end
      rq_valid = 2'b00;

      // Backpressure on port 1 blocks a pending port 0 request
      tick();
      rs_ready = 2'b01;
      rq_valid[1] = 1'b1; rq_ctrl[1] = 4'b0100; rq_a[1] = 32'hFF00; rq_b[1] = 32'h0FF0;
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (rq_ready[1]) got = 1; else tick();
      end
      chk("bp_grant", {31'd0, got}, 32'd1);
      tick();
      rq_valid[1] = 1'b0;
      rq_valid[0] = 1'b1; rq_ctrl[0] = 4'b0010; rq_a[0] = 32'd1; rq_b[0] = 32'd1;
      tick();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_hold_valid", {31'd0, rs_valid[1]}, 32'd1);
         chk("bp_hold_result", rs_res[1], 32'hF0F0);
         chk("bp_req0_blocked", {31'd0, rq_ready[0]}, 32'd0);
         tick();
      end
      rs_ready = 2'b11;
      @(negedge clk);
      chk("bp_req0_blocked_accept", {31'd0, rq_ready[0]}, 32'd0);
      tick();
      @(negedge clk);
      chk("bp_resp1_cleared", {31'd0, rs_valid[1]}, 32'd0);
      chk("bp_req0_granted", {31'd0, rq_ready[0]}, 32'd1);
      tick();
      rq_valid[0] = 1'b0;
      repeat (3) tick();

      // Illegal code, shifts and signed compares
      run_op(1, 4'b0011, 32'd3, 32'd4, 32'hDEADBEEF, 1'b0, 1'b1, "illegal", waited);
      run_op(0, 4'b1011, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1'b0, "sra", waited);
      run_op(1, 4'b0111, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0, "slt", waited);
      run_op(0, 4'b1000, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0, "sltu", waited);

      // Reset during EXEC aborts the operation and restores port 0 priority
      tick();
      rq_valid[0] = 1'b1; rq_ctrl[0] = 4'b0010; rq_a[0] = 32'd3; rq_b[0] = 32'd4;
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (rq_ready[0]) got = 1; else tick();
      end
      chk("rst_grant", {31'd0, got}, 32'd1);
      tick();
      rq_valid[0] = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_resp_valid", {30'd0, rs_valid}, 32'd0);
      chk("rst_result0", rs_res[0], 32'd0);
      chk("rst_zero", {30'd0, rs_zero}, 32'd0);
      chk("rst_illegal", {30'd0, rs_ill}, 32'd0);
      chk("rst_req_ready", {30'd0, rq_ready}, 32'd0);
      chk("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
      tick();
      rq_valid = 2'b11;
      rq_ctrl[1] = 4'b0001; rq_a[1] = 32'd6; rq_b[1] = 32'd1;
      @(negedge clk);
      chk("rst_tie_port0", {30'd0, rq_ready}, 32'd1);

      // Randomised traffic checked by the model every cycle
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         seen = rq_ready;
         tick();
         reset = ($urandom_range(0, 199) == 0);
         rs_ready = 2'($urandom_range(0, 3));
         for (int p = 0; p < 2; p++) begin
            if (seen[p] || !rq_valid[p]) begin
               rq_valid[p] = ($urandom_range(0, 2) != 0);
               rq_ctrl[p]  = 4'($urandom_range(0, 15));
               rq_a[p]     = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
               rq_b[p]     = ($urandom_range(0, 3) == 0) ? rq_a[p] : $urandom;
            end else if ($urandom_range(0, 19) == 0) begin
               rq_valid[p] = 1'b0;
            end
         end
      end
      reset = 1'b0;
      rq_valid = 2'b00;
      rs_ready = 2'b11;
      repeat (10) tick();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
